// File: rtl/smem_mem_pkg.sv
// Shared constants, arbiter state encoding and a constant-evaluable clog2 for the
// memory-request path.
package smem_mem_pkg;

    localparam int unsigned ADDR_W         = 58;
    localparam int unsigned CL_W           = 512;
    localparam int unsigned READ_NUM_WIDTH = 6;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StArb   = 3'b010,
        StDrain = 3'b100
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/req_tag_fifo.sv
// Requester-ID FIFO: records who owns each in-flight pair so responses can be routed
// back in order. Push and pop may coincide, including when full or empty.
module req_tag_fifo
    import smem_mem_pkg::*;
#(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? clog2(Depth) : 1;
    localparam int unsigned CntW = clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (32'(wr_ptr_q) == Depth - 1) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (32'(rd_ptr_q) == Depth - 1) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/bwt_req_arbiter.sv
// Round-robin arbiter sharing the paired (k,l) memory-request port, with in-order
// response routing by requester tag, an outstanding-pair limit and a drain handshake.
module bwt_req_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = smem_mem_pkg::ADDR_W,
    parameter int unsigned CL_W     = smem_mem_pkg::CL_W,
    parameter int unsigned MAX_OUT  = 16,
    localparam int unsigned OutW    = smem_mem_pkg::clog2(MAX_OUT + 1)
) (
    input  logic                      CLK_200M,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      enable,
    input  logic                      drain_req,
    output logic                      drained,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_k,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_l,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [ADDR_W-1:0]         fifo_addr_1,
    output logic [ADDR_W-1:0]         fifo_addr_2,
    input  logic                      rsp_pair_valid,
    input  logic [CL_W-1:0]           rsp_k_data,
    input  logic [CL_W-1:0]           rsp_l_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [CL_W-1:0]           rsp_k_out,
    output logic [CL_W-1:0]           rsp_l_out,
    output logic [OutW-1:0]           outstanding,
    output logic                      err_orphan
);

    import smem_mem_pkg::*;

    localparam int unsigned IdxW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic              drained_q, drained_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OutW-1:0]   out_q, out_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_1_q, addr_1_d;
    logic [ADDR_W-1:0] addr_2_q, addr_2_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [CL_W-1:0]   rsp_k_q, rsp_k_d;
    logic [CL_W-1:0]   rsp_l_q, rsp_l_d;
    logic              err_q, err_d;

    logic              gnt_found;
    logic [IdxW-1:0]   gnt_idx;
    logic [ADDR_W-1:0] sel_k, sel_l;
    logic              grant_ok, transfer, rsp_pop;
    logic [IdxW-1:0]   tag_dout;
    logic              tag_full, tag_empty;

    // Two passes: first from rr_ptr upward, then wrap around from index 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (i >= 32'(rr_ptr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        sel_k = '0;
        sel_l = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IdxW'(i)) begin
                sel_k = req_addr_k[i*ADDR_W +: ADDR_W];
                sel_l = req_addr_l[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign grant_ok = (state_q == StArb) && !stall && (out_q < OutW'(MAX_OUT)) &&
                      !tag_full && !clear;
    assign transfer = grant_ok && gnt_found;
    assign rsp_pop  = rsp_pair_valid && !tag_empty && !clear;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    req_tag_fifo #(
        .Width (IdxW),
        .Depth (MAX_OUT)
    ) u_tag_fifo (
        .clk   (CLK_200M),
        .rst_n (reset_n),
        .clear (clear),
        .push  (transfer),
        .pop   (rsp_pop),
        .din   (gnt_idx),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_comb begin
        state_d     = state_q;
        drained_d   = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        out_d       = out_q;
        wr_en_d     = transfer;
        addr_1_d    = addr_1_q;
        addr_2_d    = addr_2_q;
        rsp_valid_d = '0;
        rsp_k_d     = rsp_k_q;
        rsp_l_d     = rsp_l_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArb;
            end
            StArb: begin
                if (drain_req) state_d = StDrain;
                else if (!enable) state_d = StIdle;
            end
            StDrain: begin
                if (out_q == '0) begin
                    state_d   = StIdle;
                    drained_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (transfer) begin
            addr_1_d = sel_k;
            addr_2_d = sel_l;
            rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IdxW'(1);
        end

        if (rsp_pop) begin
            rsp_valid_d[tag_dout] = 1'b1;
            rsp_k_d = rsp_k_data;
            rsp_l_d = rsp_l_data;
        end else if (rsp_pair_valid) begin
            err_d = 1'b1;
        end

        if (transfer && !rsp_pop) begin
            out_d = out_q + OutW'(1);
        end else if (!transfer && rsp_pop) begin
            out_d = out_q - OutW'(1);
        end

        if (clear) begin
            state_d     = StIdle;
            drained_d   = 1'b0;
            rr_ptr_d    = '0;
            out_d       = '0;
            wr_en_d     = 1'b0;
            addr_1_d    = '0;
            addr_2_d    = '0;
            rsp_valid_d = '0;
            rsp_k_d     = '0;
            rsp_l_d     = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge CLK_200M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            drained_q   <= 1'b0;
            rr_ptr_q    <= '0;
            out_q       <= '0;
            wr_en_q     <= 1'b0;
            addr_1_q    <= '0;
            addr_2_q    <= '0;
            rsp_valid_q <= '0;
            rsp_k_q     <= '0;
            rsp_l_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drained_q   <= drained_d;
            rr_ptr_q    <= rr_ptr_d;
            out_q       <= out_d;
            wr_en_q     <= wr_en_d;
            addr_1_q    <= addr_1_d;
            addr_2_q    <= addr_2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_k_q     <= rsp_k_d;
            rsp_l_q     <= rsp_l_d;
            err_q       <= err_d;
        end
    end

    assign drained     = drained_q;
    assign fifo_wr_en  = wr_en_q;
    assign fifo_addr_1 = addr_1_q;
    assign fifo_addr_2 = addr_2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_k_out   = rsp_k_q;
    assign rsp_l_out   = rsp_l_q;
    assign outstanding = out_q;
    assign err_orphan  = err_q;

endmodule

// File: tb/tb_bwt_req_arbiter.sv
// Bench for bwt_req_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of grants, tags and the drain handshake.
module tb_bwt_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 58;
    localparam int CW = 512;
    localparam int MO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, clear, enable, drain_req, drained, stall;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr_k, req_addr_l;
    logic              fifo_wr_en, rsp_pair_valid, err_orphan;
    logic [AW-1:0]     fifo_addr_1, fifo_addr_2;
    logic [CW-1:0]     rsp_k_data, rsp_l_data, rsp_k_out, rsp_l_out;
    logic [4:0]        outstanding;

    bwt_req_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .CL_W    (CW),
        .MAX_OUT (MO)
    ) dut (
        .CLK_200M       (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .enable         (enable),
        .drain_req      (drain_req),
        .drained        (drained),
        .stall          (stall),
        .req_valid      (req_valid),
        .req_addr_k     (req_addr_k),
        .req_addr_l     (req_addr_l),
        .req_ready      (req_ready),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_addr_1    (fifo_addr_1),
        .fifo_addr_2    (fifo_addr_2),
        .rsp_pair_valid (rsp_pair_valid),
        .rsp_k_data     (rsp_k_data),
        .rsp_l_data     (rsp_l_data),
        .rsp_valid      (rsp_valid),
        .rsp_k_out      (rsp_k_out),
        .rsp_l_out      (rsp_l_out),
        .outstanding    (outstanding),
        .err_orphan     (err_orphan)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 arbitrating, 2 draining; in-flight owners in a queue.
    int            m_state;
    int            m_rr;
    int            m_tags[$];
    logic          m_wr, m_err, m_drn;
    logic [AW-1:0] m_a1, m_a2;
    logic [NR-1:0] m_rv;
    logic [CW-1:0] m_k, m_l;
    logic [NR-1:0] exp_ready, obs_ready;

    function automatic logic [AW-1:0] rand_addr();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[AW-1:0];
    endfunction

    function automatic logic [CW-1:0] rand_line();
        logic [CW-1:0] t;
        for (int i = 0; i < CW / 32; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    function automatic logic [NR-1:0] model_ready();
        logic [NR-1:0] r;
        int j;
        r = '0;
        if (m_state == 1 && !stall && m_tags.size() < MO && !clear) begin
            for (int i = 0; i < NR; i++) begin
                j = (m_rr + i) % NR;
                if (req_valid[j] && r == '0) r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rr = 0; m_tags.delete();
        m_wr = 0; m_err = 0; m_drn = 0; m_a1 = '0; m_a2 = '0;
        m_rv = '0; m_k = '0; m_l = '0;
    endtask

    task automatic model_edge();
        int pre, gi, id;
        if (clear) begin
            model_reset();
            return;
        end
        pre = m_tags.size();
        gi = -1;
        for (int i = 0; i < NR; i++) if (exp_ready[i]) gi = i;
        m_drn = 1'b0;
        m_rv  = '0;
        if (rsp_pair_valid) begin
            if (pre > 0) begin
                id = m_tags.pop_front();
                m_rv[id] = 1'b1;
                m_k = rsp_k_data;
                m_l = rsp_l_data;
            end else begin
                m_err = 1'b1;
            end
        end
        m_wr = (gi >= 0);
        if (gi >= 0) begin
            m_tags.push_back(gi);
            m_rr = (gi + 1) % NR;
            m_a1 = req_addr_k[gi*AW +: AW];
            m_a2 = req_addr_l[gi*AW +: AW];
        end
        case (m_state)
            0: if (enable) m_state = 1;
            1: if (drain_req) m_state = 2; else if (!enable) m_state = 0;
            default: if (pre == 0) begin m_state = 0; m_drn = 1'b1; end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        obs_ready = req_ready;
        exp_ready = model_ready();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; enable = 0; drain_req = 0; stall = 0; req_valid = '0;
        rsp_pair_valid = 0; rsp_k_data = '0; rsp_l_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr_k[i*AW +: AW] = rand_addr();
            req_addr_l[i*AW +: AW] = rand_addr();
        end
    endtask

    // Synchronous flush, then one cycle with enable to reach the arbitrating state.
    task automatic flush_and_enable();
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
        enable = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        #23;
        reset_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        n_vec++;
        if ({req_ready, fifo_wr_en, rsp_valid, outstanding, err_orphan, drained} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h want 0",
                     {req_ready, fifo_wr_en, rsp_valid, outstanding, err_orphan, drained});
        end
        n_vec++;
        if ({fifo_addr_1, fifo_addr_2, rsp_k_out, rsp_l_out} !== '0) begin
            n_err++;
            $display("FAIL reset_data: addr1 %h addr2 %h want 0", fifo_addr_1, fifo_addr_2);
        end
    endtask

    task automatic test_single();
        flush_and_enable();
        req_valid = 4'b0100;
        req_addr_k[2*AW +: AW] = 58'h100;
        req_addr_l[2*AW +: AW] = 58'h200;
        tick();
        req_valid = '0;
        n_vec++;
        if (obs_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b want 0100", obs_ready);
        end
        n_vec++;
        if ({fifo_wr_en, fifo_addr_1, fifo_addr_2} !== {1'b1, 58'h100, 58'h200}) begin
            n_err++;
            $display("FAIL single_fifo: got en %b a1 %h a2 %h want 1 100 200",
                     fifo_wr_en, fifo_addr_1, fifo_addr_2);
        end
        n_vec++;
        if (outstanding !== 5'd1) begin
            n_err++; $display("FAIL single_out: got %0d want 1", outstanding);
        end
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] k;
        flush_and_enable();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (obs_ready !== 4'(1 << (i % NR))) begin
                n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, obs_ready,
                                  4'(1 << (i % NR)));
            end
        end
        req_valid = '0;
        n_vec++;
        if (outstanding !== 5'd8) begin
            n_err++; $display("FAIL rr_out8: got %0d want 8", outstanding);
        end
        for (int i = 0; i < 8; i++) begin
            k = rand_line();
            rsp_k_data = k;
            rsp_l_data = ~k;
            rsp_pair_valid = 1;
            tick();
            n_vec++;
            if (rsp_valid !== 4'(1 << (i % NR)) || rsp_k_out !== k || rsp_l_out !== ~k) begin
                n_err++; $display("FAIL rr_rsp%0d: got %b want %b (or data differs)", i,
                                  rsp_valid, 4'(1 << (i % NR)));
            end
        end
        rsp_pair_valid = 0;
        n_vec++;
        if (outstanding !== 5'd0) begin
            n_err++; $display("FAIL rr_out0: got %0d want 0", outstanding);
        end
    endtask

    task automatic test_limit();
        int grants, extra;
        flush_and_enable();
        req_valid = 4'b0001;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_ready[0]) grants++;
        end
        n_vec++;
        if (grants != MO || obs_ready !== 4'b0000 || outstanding !== 5'd16) begin
            n_err++; $display("FAIL limit_cap: got %0d grants out %0d want 16 16", grants,
                              outstanding);
        end
        rsp_pair_valid = 1;
        tick();
        rsp_pair_valid = 0;
        extra = obs_ready[0] ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (obs_ready[0]) extra++;
        end
        req_valid = '0;
        n_vec++;
        if (extra != 1 || outstanding !== 5'd16) begin
            n_err++; $display("FAIL limit_refill: got %0d grants out %0d want 1 16", extra,
                              outstanding);
        end
    endtask

    task automatic test_stall();
        flush_and_enable();
        req_valid = 4'hF;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs_ready !== 4'b0000 || (i > 0 && fifo_wr_en !== 1'b0)) begin
                n_err++; $display("FAIL stall_hold%0d: got ready %b wr %b want 0 0", i,
                                  obs_ready, fifo_wr_en);
            end
        end
        stall = 0;
        tick();
        req_valid = '0;
        n_vec++;
        if (obs_ready !== 4'b0010) begin
            n_err++; $display("FAIL stall_resume: got %b want 0010", obs_ready);
        end
    endtask

    task automatic test_drain();
        int g, seen, late;
        flush_and_enable();
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        req_valid = '0;
        drain_req = 1;
        tick();
        req_valid = 4'hF;
        g = 0;
        for (int i = 0; i < 6; i++) begin
            rsp_pair_valid = (i >= 3);
            tick();
            if (obs_ready != '0) g++;
        end
        rsp_pair_valid = 0;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            tick();
            if (drained) seen++;
        end
        enable = 0;
        drain_req = 0;
        late = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (drained) late++;
            if (obs_ready != '0) g++;
        end
        req_valid = '0;
        n_vec++;
        if (seen != 1 || late != 0) begin
            n_err++; $display("FAIL drain_pulse: got %0d+%0d pulses want 1+0", seen, late);
        end
        n_vec++;
        if (g != 0 || outstanding !== 5'd0) begin
            n_err++; $display("FAIL drain_nogrant: got %0d grants out %0d want 0 0", g,
                              outstanding);
        end
    endtask

    task automatic test_orphan();
        flush_and_enable();
        rsp_pair_valid = 1;
        rsp_k_data = rand_line();
        tick();
        rsp_pair_valid = 0;
        n_vec++;
        if ({err_orphan, rsp_valid, outstanding} !== {1'b1, 4'b0, 5'd0}) begin
            n_err++; $display("FAIL orphan: got err %b rv %b out %0d want 1 0 0", err_orphan,
                              rsp_valid, outstanding);
        end
        tick();
        n_vec++;
        if (err_orphan !== 1'b1) begin
            n_err++; $display("FAIL orphan_sticky: got %b want 1", err_orphan);
        end
    endtask

    task automatic test_random();
        flush_and_enable();
        for (int c = 0; c < 600; c++) begin
            clear     = ($urandom_range(0, 79) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            drain_req = ($urandom_range(0, 24) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            req_valid = 4'($urandom());
            rsp_pair_valid = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 25 : 70));
            rsp_k_data = rand_line();
            rsp_l_data = rand_line();
            for (int i = 0; i < NR; i++) begin
                req_addr_k[i*AW +: AW] = rand_addr();
                req_addr_l[i*AW +: AW] = rand_addr();
            end
            tick();
            n_vec++;
            if (obs_ready !== exp_ready) begin
                n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_ready, exp_ready);
            end
            n_vec++;
            if (fifo_wr_en !== m_wr || (m_wr && {fifo_addr_1, fifo_addr_2} !== {m_a1, m_a2}))
            begin
                n_err++; $display("FAIL rnd_fifo c%0d: got %b %h %h want %b %h %h", c,
                                  fifo_wr_en, fifo_addr_1, fifo_addr_2, m_wr, m_a1, m_a2);
            end
            n_vec++;
            if (rsp_valid !== m_rv || (m_rv != '0 && {rsp_k_out, rsp_l_out} !== {m_k, m_l}))
            begin
                n_err++; $display("FAIL rnd_rsp c%0d: got %b want %b (or data differs)", c,
                                  rsp_valid, m_rv);
            end
            n_vec++;
            if (int'(outstanding) != m_tags.size() || err_orphan !== m_err ||
                drained !== m_drn) begin
                n_err++; $display("FAIL rnd_status c%0d: got out %0d err %b drn %b want %0d %b %b",
                                  c, outstanding, err_orphan, drained, m_tags.size(), m_err,
                                  m_drn);
            end
        end
    endtask

    task automatic test_async_reset();
        flush_and_enable();
        req_valid = 4'hF;
        rsp_pair_valid = 1;
        rsp_k_data = rand_line();
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset_n = 0;
        #1;
        n_vec++;
        if ({req_ready, fifo_wr_en, rsp_valid, outstanding, err_orphan, drained,
             fifo_addr_1, fifo_addr_2, rsp_k_out, rsp_l_out} !== '0) begin
            n_err++; $display("FAIL async_reset: got ready %b wr %b rv %b out %0d", req_ready,
                              fifo_wr_en, rsp_valid, outstanding);
        end
        idle_inputs();
        #3;
        reset_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_limit();
        test_stall();
        test_drain();
        test_orphan();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
